// File: rtl/fp_mul_norm_round.sv
// Normalize/round/pack back end of the cascade FP multiplier: normalize, round, pack, one op per cycle.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_mul_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sign,
  input  logic [EXP_W:0]           in_exp_sum,
  input  logic [2*MAN_W+1:0]       in_prod,
  input  logic                     in_nan,
  input  logic                     in_inf,
  input  logic                     in_zero,
  output logic                     out_valid,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic                     out_inexact
);
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + MAN_W + 1;
  localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_E   = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E  = EW'(0);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [RW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q, s1_sign_d;
  logic signed [EW-1:0]    s1_exp_q, s1_exp_d;
  logic [MAN_W-1:0]        s1_mant_q, s1_mant_d;
  logic                    s1_guard_q, s1_guard_d;
  logic                    s1_sticky_q, s1_sticky_d;
  logic                    s1_nan_q, s1_nan_d;
  logic                    s1_inf_q, s1_inf_d;
  logic                    s1_zero_q, s1_zero_d;

  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_sign_q, s2_sign_d;
  logic signed [EW-1:0]    s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0]        s2_mant_q, s2_mant_d;
  logic                    s2_lost_q, s2_lost_d;
  logic                    s2_nan_q, s2_nan_d;
  logic                    s2_inf_q, s2_inf_d;
  logic                    s2_zero_q, s2_zero_d;

  logic                    out_valid_q, out_valid_d;
  logic [RW-1:0]           out_result_q, out_result_d;
  logic                    out_overflow_q, out_overflow_d;
  logic                    out_underflow_q, out_underflow_d;
  logic                    out_inexact_q, out_inexact_d;

  // Normalize: a product >= 2.0 shifts right one place and bumps the exponent.
  always_comb begin
    s1_valid_d  = in_valid;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_mant_d   = s1_mant_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_nan_d    = s1_nan_q;
    s1_inf_d    = s1_inf_q;
    s1_zero_d   = s1_zero_q;
    if (in_valid) begin
      s1_sign_d = in_sign;
      s1_nan_d  = in_nan;
      s1_inf_d  = in_inf;
      s1_zero_d = in_zero;
      if (in_prod[2*MAN_W+1]) begin
        s1_mant_d   = in_prod[2*MAN_W:MAN_W+1];
        s1_guard_d  = in_prod[MAN_W];
        s1_sticky_d = |in_prod[MAN_W-1:0];
        s1_exp_d    = $signed({1'b0, in_exp_sum}) - BIAS_E + ONE_E;
      end else begin
        s1_mant_d   = in_prod[2*MAN_W-1:MAN_W];
        s1_guard_d  = in_prod[MAN_W-1];
        s1_sticky_d = |in_prod[MAN_W-2:0];
        s1_exp_d    = $signed({1'b0, in_exp_sum}) - BIAS_E;
      end
    end else begin
      s1_sign_d = s1_sign_q;
    end
  end

  // Round the normalized mantissa; a carry-out wraps the mantissa to zero and bumps the exponent.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_mant_d  = s2_mant_q;
    s2_lost_d  = s2_lost_q;
    s2_nan_d   = s2_nan_q;
    s2_inf_d   = s2_inf_q;
    s2_zero_d  = s2_zero_q;
    if (s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      s2_lost_d = s1_guard_q | s1_sticky_q;
      s2_nan_d  = s1_nan_q;
      s2_inf_d  = s1_inf_q;
      s2_zero_d = s1_zero_q;
`ifdef FP_MUL_RNE_EN
      begin
        logic             round_inc;
        logic             carry;
        logic [MAN_W-1:0] mant_rnd;
        round_inc         = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
        {carry, mant_rnd} = {1'b0, s1_mant_q} + {{MAN_W{1'b0}}, round_inc};
        s2_mant_d         = mant_rnd;
        s2_exp_d          = s1_exp_q + $signed({{(EW-1){1'b0}}, carry});
      end
`else
      s2_mant_d = s1_mant_q;
      s2_exp_d  = s1_exp_q;
`endif
    end else begin
      s2_sign_d = s2_sign_q;
    end
  end

  // Range check and pack; special-case flags override the arithmetic result.
  always_comb begin
    out_valid_d     = s2_valid_q;
    out_result_d    = out_result_q;
    out_overflow_d  = out_overflow_q;
    out_underflow_d = out_underflow_q;
    out_inexact_d   = out_inexact_q;
    if (s2_valid_q) begin
      out_overflow_d  = 1'b0;
      out_underflow_d = 1'b0;
      out_inexact_d   = 1'b0;
      if (s2_nan_q) begin
        out_result_d = QNAN;
      end else if (s2_inf_q) begin
        out_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_zero_q) begin
        out_result_d = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      end else if (s2_exp_q >= EXP_MAX) begin
        out_result_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        out_overflow_d = 1'b1;
        out_inexact_d  = 1'b1;
      end else if (s2_exp_q <= ZERO_E) begin
        out_result_d    = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        out_underflow_d = 1'b1;
        out_inexact_d   = 1'b1;
      end else begin
        out_result_d  = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_mant_q};
        out_inexact_d = s2_lost_q;
      end
    end else begin
      out_result_d = out_result_q;
    end
  end

  // Pipeline registers; reset discards every in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q      <= 1'b0;
      s1_sign_q       <= 1'b0;
      s1_exp_q        <= '0;
      s1_mant_q       <= '0;
      s1_guard_q      <= 1'b0;
      s1_sticky_q     <= 1'b0;
      s1_nan_q        <= 1'b0;
      s1_inf_q        <= 1'b0;
      s1_zero_q       <= 1'b0;
      s2_valid_q      <= 1'b0;
      s2_sign_q       <= 1'b0;
      s2_exp_q        <= '0;
      s2_mant_q       <= '0;
      s2_lost_q       <= 1'b0;
      s2_nan_q        <= 1'b0;
      s2_inf_q        <= 1'b0;
      s2_zero_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
      out_inexact_q   <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_sign_q       <= s1_sign_d;
      s1_exp_q        <= s1_exp_d;
      s1_mant_q       <= s1_mant_d;
      s1_guard_q      <= s1_guard_d;
      s1_sticky_q     <= s1_sticky_d;
      s1_nan_q        <= s1_nan_d;
      s1_inf_q        <= s1_inf_d;
      s1_zero_q       <= s1_zero_d;
      s2_valid_q      <= s2_valid_d;
      s2_sign_q       <= s2_sign_d;
      s2_exp_q        <= s2_exp_d;
      s2_mant_q       <= s2_mant_d;
      s2_lost_q       <= s2_lost_d;
      s2_nan_q        <= s2_nan_d;
      s2_inf_q        <= s2_inf_d;
      s2_zero_q       <= s2_zero_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_overflow_q  <= out_overflow_d;
      out_underflow_q <= out_underflow_d;
      out_inexact_q   <= out_inexact_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = out_overflow_q;
  assign out_underflow = out_underflow_q;
  assign out_inexact   = out_inexact_q;
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round with hand-computed IEEE-754 single-precision results.
module tb_fp_mul_norm_round;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [8:0]  in_exp_sum = 9'd0;
  logic [47:0] in_prod = 48'd0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp_sum(in_exp_sum), .in_prod(in_prod), .in_nan(in_nan),
    .in_inf(in_inf), .in_zero(in_zero), .out_valid(out_valid),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One isolated operation: inputs applied at a falling edge, result checked after the second following rising edge.
  task automatic run_op(input string tag, input logic s, input logic [8:0] es, input logic [47:0] p,
                        input logic n, input logic i, input logic z,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags);
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp_sum = es; in_prod = p;
    in_nan = n; in_inf = i; in_zero = z;
    @(negedge clk);
    in_valid = 1'b0; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
    check({tag, "_v_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_v_early2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_flags"}, {29'd0, out_overflow, out_underflow, out_inexact}, {29'd0, exp_flags});
    @(negedge clk);
    check({tag, "_v_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hold"}, out_result, exp_res);
  endtask

  initial begin
    logic [31:0] exp_tie2;
    logic [31:0] exp_carry;
`ifdef FP_MUL_RNE_EN
    exp_tie2  = 32'h3F80_0002;
    exp_carry = 32'h4080_0000;
`else
    exp_tie2  = 32'h3F80_0001;
    exp_carry = 32'h407F_FFFF;
`endif
    // Reset state while rst is held low.
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul15", 1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000);
    run_op("tie_even", 1'b0, 9'd254, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001);
    run_op("tie_odd", 1'b0, 9'd254, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, exp_tie2, 3'b001);
    run_op("rnd_carry", 1'b0, 9'd254, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, exp_carry, 3'b001);
    run_op("overflow", 1'b1, 9'd382, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 3'b101);
    run_op("underflow", 1'b0, 9'd100, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011);
    run_op("nan", 1'b1, 9'd382, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000);
    run_op("inf", 1'b1, 9'd100, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b1, 32'hFF80_0000, 3'b000);
    run_op("zero", 1'b1, 9'd382, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000);

    // Five back-to-back operations: 2.25 * 2^i for i = 0..4, out_valid for five consecutive cycles.
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 7) begin
        check($sformatf("stream_v%0d", cyc), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream_r%0d", cyc), out_result, 32'h4010_0000 + ((cyc - 3) << 23));
      end else begin
        check($sformatf("stream_v%0d", cyc), {31'd0, out_valid}, 32'd0);
      end
      if (cyc < 5) begin
        in_valid = 1'b1; in_sign = 1'b0; in_exp_sum = 9'(254 + cyc);
        in_prod = 48'h9000_0000_0000;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sign = 1'b0; in_exp_sum = 9'd254; in_prod = 48'h9000_0000_0000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_result", out_result, 32'h4010_0000);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_result", out_result, 32'd0);
    check("async_rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_v%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_norm_round.md
# fp_mul_norm_round

Normalize-and-round back end of the synchronous cascade floating-point multiplier. It consumes the raw mantissa product together with the sign, exponent sum and special-case flags, which the fixed-latency delay line has already aligned to the product. It produces a packed IEEE-754 result through a 2-stage valid-qualified pipeline with throughput of one operation per cycle. It has no backpressure because the upstream cascade is fixed-latency.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width (hidden bit excluded)
- BIAS, 127, exponent bias
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  input operation valid this cycle
- in_sign  input  1  product sign (sign_a XOR sign_b)
- in_exp_sum  input  EXP_W+1  biased exponent sum e_a+e_b, unsigned
- in_prod  input  2*MAN_W+2  product of 1.f_a × 1.f_b, binary point below bit 2*MAN_W
- in_nan, in_inf, in_zero  input  1 each  special-case flags from the unpack stage (inf×0 arrives as in_nan)
- out_valid  output  1  result valid
- out_result  output  EXP_W+MAN_W+1  packed {sign, exp, frac}
- out_overflow, out_underflow, out_inexact  output  1 each  exception flags, qualified by out_valid

## Operation
- Stage 1 (normalize), with M = MAN_W and P = in_prod:
  - If P[2M+1]=1: mant=P[2M:M+1], guard=P[M], sticky=|P[M-1:0], exp=in_exp_sum−BIAS+1.
  - Otherwise: mant=P[2M-1:M], guard=P[M-1], sticky=|P[M-2:0], exp=in_exp_sum−BIAS.
  - exp is signed, EXP_W+2 bits wide, with no wrap over the full input range.
- Stage 2 (round/pack):
  - Apply the rounding rule (see Configuration).
  - Mantissa carry-out (all ones +1) gives mant=0 and exp+1.
  - Then check in order:
    - exp ≥ 2^EXP_W−1: ±infinity, out_overflow=1, out_inexact=1.
    - exp ≤ 0: flush to ±0, out_underflow=1, out_inexact=1. Subnormals are not supported.
    - Otherwise: out_inexact = guard|sticky.
- Special-case priority is nan > inf > zero > normal:
  - nan gives canonical qNaN: sign 0, exp all ones, frac MSB 1, other bits 0.
  - inf gives ±infinity.
  - zero gives ±0.
  - All special cases clear every flag.
- Data registers load only when the stage's valid is 1. When the stage's valid is 0 they hold, so out_result keeps its last value while out_valid=0.

## Timing
- Latency 2: in_valid sampled at edge k gives out_valid/out_result at edge k+2.
- Accepts a new operation every cycle; back-to-back operations exit in order.
- No stall input; bubbles propagate unchanged.
- Reset (rst=0, asynchronous):
  - All valid bits, out_result, and all flags go to 0 immediately.
  - In-flight operations are discarded; no output is produced for them after rst deasserts.
- First input accepted on the first rising edge with rst=1.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even. Increment mant when guard & (sticky | mant[0]).
- FP_MUL_RNE_EN undefined: truncate (round toward zero). Never increment. The carry path and overflow-from-rounding logic are removed; out_inexact is unchanged.

## Test plan
(Default parameters for all scenarios.)
- 1.5×1.5: in_exp_sum=254, in_prod=0x9000_0000_0000 -> out_result=0x40100000, no flags, 2 cycles later.
- Tie-to-even: in_exp_sum=254, in_prod=0x4000_0040_0000 -> 0x3F800000, inexact=1. With in_prod=0x4000_00C0_0000 -> 0x3F800002 (RNE) / 0x3F800001 (truncate).
- Rounding carry: in_exp_sum=254, in_prod=0xFFFF_FFFF_FFFF -> 0x40800000 (RNE) / 0x407FFFFF (truncate), inexact=1.
- Overflow/underflow:
  - in_exp_sum=382, in_prod=0x4000_0000_0000, sign 1 -> 0xFF800000, overflow=1.
  - in_exp_sum=100, sign 0 -> 0x00000000, underflow=1.
- Specials: in_nan=1 -> 0x7FC00000. in_inf=1, sign 1 -> 0xFF800000. in_zero=1, sign 1 -> 0x80000000. All flags 0 in each case.
- Stream and reset:
  - 5 back-to-back valid inputs -> 5 consecutive out_valid cycles, in order.
  - rst pulsed low after the 3rd input -> outputs 0 immediately, and no further out_valid for the 3 in-flight inputs.
